// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard unit: per-operand forwarding, multi-cycle load-use stalls, a freeze
// around the multi-cycle execute unit, and saturating stall/flush performance counters.
module hazard_ctrl_mc #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RS   = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RS*ADDR_W-1:0] rs_d,
  input  logic [NUM_RS*ADDR_W-1:0] rs_e,
  input  logic [ADDR_W-1:0]        rd_e,
  input  logic [ADDR_W-1:0]        rd_m,
  input  logic [ADDR_W-1:0]        rd_w,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  input  logic                     mem_read_e,
  input  logic                     pc_src_e,
  input  logic                     mc_start_e,
  input  logic                     mc_done,
  input  logic                     cnt_clear,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     stall_e,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     flush_m,
  output logic [NUM_RS*2-1:0]      forward_e,
  output logic                     busy,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  typedef enum logic [1:0] {StRun, StLoadWait, StMcWait} stateE;

  localparam logic [2:0] LoadWaitInit = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  stateE            stateQ, stateD;
  logic [2:0]       waitQ, waitD;
  logic [CNT_W-1:0] stallCntQ, flushCntQ;

  logic [NUM_RS*2-1:0] fwd;
  logic loadUse;
  logic stallF, stallD, stallE, flushD, flushE, flushM, branchFlush;

  // Forwarding; M is the younger result so it wins over W, and x0 is never forwarded.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (reg_write_m && (rd_m != '0) && (rd_m == rs_e[i*ADDR_W +: ADDR_W])) begin
        fwd[2*i +: 2] = 2'b10;
      end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e[i*ADDR_W +: ADDR_W])) begin
        fwd[2*i +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    loadUse = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (mem_read_e && (rd_e != '0) && (rd_e == rs_d[i*ADDR_W +: ADDR_W])) begin
        loadUse = 1'b1;
      end
    end
  end

  always_comb begin
    stateD      = stateQ;
    waitD       = waitQ;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    branchFlush = 1'b0;
    unique case (stateQ)
      StRun: begin
        if (mc_start_e && !mc_done) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
          stateD = StMcWait;
        end else if (pc_src_e) begin
          // A taken branch squashes the dependent instruction, so no load-use stall.
          flushD      = 1'b1;
          flushE      = 1'b1;
          branchFlush = 1'b1;
        end else if (loadUse) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
          if (LOAD_LAT > 1) begin
            stateD = StLoadWait;
            waitD  = LoadWaitInit;
          end
        end
      end
      StLoadWait: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
        waitD  = waitQ - 3'd1;
        if (waitQ <= 3'd1) begin
          stateD = StRun;
        end
      end
      StMcWait: begin
        // mc_start_e is still high here; only mc_done matters.
        if (mc_done) begin
          stateD = StRun;
        end else begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
        end
      end
      default: stateD = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StRun;
      waitQ  <= '0;
    end else begin
      stateQ <= stateD;
      waitQ  <= waitD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else if (cnt_clear) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (stallD && (stallCntQ != CntMax)) begin
        stallCntQ <= stallCntQ + CNT_W'(1);
      end
      if (branchFlush && (flushCntQ != CntMax)) begin
        flushCntQ <= flushCntQ + CNT_W'(1);
      end
    end
  end

  // Control outputs are forced low while reset is held, independent of the clock.
  assign stall_f   = rst_n & stallF;
  assign stall_d   = rst_n & stallD;
  assign stall_e   = rst_n & stallE;
  assign flush_d   = rst_n & flushD;
  assign flush_e   = rst_n & flushE;
  assign flush_m   = rst_n & flushM;
  assign forward_e = rst_n ? fwd : '0;
  assign busy      = rst_n & (stateQ != StRun);
  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised next-generation hazard/conflict unit for the 5-stage pipelined RISC-V core (F/D/E/M/W).
- Generalises forwarding to NUM_RS source operands.
- Supports multi-cycle load-use stalls of configurable memory latency.
- Adds a start/done handshake that freezes the pipeline around a multi-cycle execute unit (mul/div).
- Keeps saturating stall/flush performance counters.

Parameters:
- ADDR_W, 5, register address width.
- NUM_RS, 2, source operands per instruction (1..3).
- LOAD_LAT, 1, total load-use stall cycles (1..7).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_d  in  NUM_RS*ADDR_W  source regs in Decode; operand i at [i*ADDR_W +: ADDR_W].
- rs_e  in  NUM_RS*ADDR_W  source regs in Execute.
- rd_e, rd_m, rd_w  in  ADDR_W  destination regs in E/M/W.
- reg_write_m, reg_write_w  in  1  write enables in M/W.
- mem_read_e  in  1  instruction in E is a load.
- pc_src_e  in  1  taken branch/jump resolved in E.
- mc_start_e  in  1  instruction in E is a multi-cycle op (level).
- mc_done  in  1  multi-cycle unit result valid this cycle.
- cnt_clear  in  1  synchronous clear of both counters.
- stall_f, stall_d, stall_e  out  1  hold PC / D / E pipeline registers.
- flush_d, flush_e, flush_m  out  1  bubble D / E / M pipeline registers.
- forward_e  out  NUM_RS*2  per operand: 00 regfile, 10 from M, 01 from W.
- busy  out  1  high while state != RUN.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- States: RUN, LOAD_WAIT, MC_WAIT. Reset state is RUN; wait counter and perf counters reset to 0.
- While rst_n is low, all stall/flush outputs and busy are 0, and forward_e is 0.
- Forwarding (combinational, all states), per operand i:
  - 10 if reg_write_m and rd_m != 0 and rd_m == rs_e[i].
  - Otherwise 01 if reg_write_w and rd_w != 0 and rd_w == rs_e[i].
  - Otherwise 00.
  - M has priority over W. x0 is never forwarded.
- Load-use (RUN):
  - Condition: mem_read_e and rd_e != 0 and rd_e equals any rs_d[i].
  - That cycle: stall_f = stall_d = flush_e = 1.
  - If LOAD_LAT > 1: next state LOAD_WAIT, wait counter = LOAD_LAT-1.
- LOAD_WAIT: stall_f = stall_d = flush_e = 1; counter decrements each cycle. When the counter reaches 1, next state is RUN. The total stall is exactly LOAD_LAT cycles. The register file is write-through, so no forwarding is needed after the stall.
- Multi-cycle op (RUN):
  - mc_start_e and !mc_done: stall_f = stall_d = stall_e = flush_m = 1; next state MC_WAIT.
  - mc_start_e and mc_done in the same cycle: no stall; stay in RUN.
- MC_WAIT:
  - While !mc_done: stall_f = stall_d = stall_e = flush_m = 1.
  - Cycle with mc_done = 1: all stalls 0; next state RUN.
  - mc_start_e is ignored in MC_WAIT, so the still-high level does not retrigger.
- Branch: pc_src_e is qualified only in RUN with no multi-cycle stall; it asserts flush_d = flush_e = 1. A load-use condition in the same cycle is overridden by the branch: flush wins, no stall, no LOAD_WAIT entry.
- busy = (state != RUN).
- Counters:
  - stall_cnt += 1 on each cycle stall_d = 1.
  - flush_cnt += 1 on each cycle a branch flush is asserted.
  - Both saturate at 2^CNT_W-1.
  - cnt_clear has priority over increment.
- Reset mid-operation: async return to RUN, counters 0, outputs deasserted immediately.

Test Plan:
- Forwarding: rs_e = {5,5}, rd_m = 5, reg_write_m = 1, rd_w = 5, reg_write_w = 1 -> forward_e = 4'b1010. Repeat with rd_m = 0 -> forward_e = 4'b0101. With rs_e = {0,0} -> forward_e = 0.
- Load-use: LOAD_LAT = 3, mem_read_e = 1, rd_e = 7, rs_d[1] = 7 -> stall_f/stall_d/flush_e high for exactly 3 cycles, busy high for cycles 2-3, stall_cnt = 3.
- Multi-cycle op: mc_start_e held high; mc_done rises 4 cycles later -> stall_e and flush_m high for 4 cycles, low in the mc_done cycle, state back to RUN, no retrigger. Same-cycle start+done -> zero stall cycles.
- Branch priority: pc_src_e = 1 with a simultaneous load-use match -> flush_d = flush_e = 1, stall_f = 0, flush_cnt += 1, stay in RUN.
- Counter saturation and clear: CNT_W = 2, 5 stall cycles -> stall_cnt = 3; cnt_clear pulse with a stall active -> stall_cnt = 0.
- Reset: rst_n low during MC_WAIT -> outputs 0 asynchronously, busy = 0, counters 0. After release, state is RUN.
